// File: rtl/arb_pkg.sv
// Shared definitions for the N-requester arbiter: FSM state encoding and a
// constant-evaluable ceiling-log2 helper used to size index and counter fields.
package arb_pkg;

    // Arbiter FSM states: no owner, or exactly one owner holding the grant.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational rotating-priority picker. In fixed mode the scan starts at
// index 0; in round-robin mode it starts one past 'base' and wraps. Bits set in
// 'mask' are never eligible.
module arb_pick
    import arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  request,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] base,
    input  logic          rr_mode,
    output logic          valid,
    output logic [IW-1:0] winner,
    output logic [N-1:0]  onehot
);

    logic [N-1:0] eligible;

    assign eligible = request & ~mask;

    // Scan eligible requests from the start index upward, first hit wins.
    always_comb begin
        int start;
        int pos;
        logic [IW-1:0] idx;
        valid  = 1'b0;
        winner = '0;
        start  = 0;
        pos    = 0;
        idx    = '0;
        if (rr_mode) begin
            start = (int'(base) + 1) % N;
        end
        for (int k = 0; k < N; k++) begin
            pos = (start + k) % N;
            idx = IW'(pos);
            if (!valid && eligible[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

    // One-hot form of the winner, all zero when nothing is eligible.
    always_comb begin
        onehot = '0;
        if (valid) begin
            onehot[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-requester arbiter with fixed-priority or round-robin selection, registered
// one-hot grant and a bounded tenure of MAX_HOLD cycles (0 = unlimited).
// Handshake: a master owns the resource for every cycle its o_grant bit is
// high; it keeps ownership while it holds its i_request bit, and dropping the
// bit releases the grant at the next rising edge, where the next owner (if
// any) is granted in the same edge with no gap and no overlap.
// o_state and o_hold_cnt expose the FSM state and tenure counter for debug.
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter int N = 4,
    parameter int MAX_HOLD = 8,
    localparam int IW = clog2(N),
    localparam int HW = (clog2(MAX_HOLD + 1) < 1) ? 1 : clog2(MAX_HOLD + 1)
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic [N-1:0]  i_request,
    input  logic          i_rr_mode,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_id,
    output logic          o_busy,
    output arb_state_t    o_state,
    output logic [HW-1:0] o_hold_cnt
);

    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

    arb_state_t    state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] last, last_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [N-1:0]  grant, grant_n;
    logic          busy, busy_n;

    logic [N-1:0]  pick_mask;
    logic          pick_valid;
    logic [IW-1:0] pick_id;
    logic [N-1:0]  pick_onehot;
    logic          owner_req;
    logic          timeout;

    // The current owner is excluded from arbitration while it holds the grant.
    always_comb begin
        pick_mask = '0;
        if (state == GRANT) begin
            pick_mask[owner] = 1'b1;
        end
    end

    assign owner_req = i_request[owner];
    assign timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    arb_pick #(
        .N (N)
    ) u_pick (
        .request (i_request),
        .mask    (pick_mask),
        .base    (last),
        .rr_mode (i_rr_mode),
        .valid   (pick_valid),
        .winner  (pick_id),
        .onehot  (pick_onehot)
    );

    // Next-state logic: arbitration on entry, release and tenure expiry.
    always_comb begin
        logic take;
        logic go_idle;
        state_n = state;
        owner_n = owner;
        last_n  = last;
        hold_n  = hold_cnt;
        grant_n = grant;
        take    = 1'b0;
        go_idle = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (pick_valid) begin
                        take = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (timeout) begin
                    // No one else waiting: the owner starts a fresh tenure.
                    if (pick_valid) begin
                        take = 1'b1;
                    end else begin
                        hold_n = '0;
                    end
                end else if (MAX_HOLD != 0) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
        if (take) begin
            state_n = GRANT;
            owner_n = pick_id;
            last_n  = pick_id;
            hold_n  = '0;
            grant_n = pick_onehot;
        end
        if (go_idle) begin
            state_n = IDLE;
            owner_n = '0;
            hold_n  = '0;
            grant_n = '0;
        end
        busy_n = |grant_n;
    end

    // State, owner, pointer, counter and output registers with sync reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= LAST_INIT;
            hold_cnt <= '0;
            grant    <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            last     <= last_n;
            hold_cnt <= hold_n;
            grant    <= grant_n;
            busy     <= busy_n;
        end
    end

    assign o_grant    = grant;
    assign o_grant_id = owner;
    assign o_busy     = busy;
    assign o_state    = state;
    assign o_hold_cnt = hold_cnt;

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised N-requester bus arbiter with selectable fixed-priority or round-robin arbitration, registered one-hot grant, and bounded grant tenure. Successor to the 3-requester fixed-priority grant FSM. Sits between N masters and a single shared resource. A master keeps its grant while it holds its request, up to MAX_HOLD cycles.

## Interface
- N, default 4: number of requesters, 2..16.
- MAX_HOLD, default 8: maximum consecutive grant cycles per tenure; 0 means unlimited.
- Clock  in  1  rising-edge clock.
- Resetn  in  1  reset, synchronous, active-low; clock Clock.
- i_request  in  N  request vector; bit i belongs to master i.
- i_rr_mode  in  1  1 selects round-robin, 0 selects fixed priority (index 0 highest).
- o_grant  out  N  registered one-hot grant, or all zero.
- o_grant_id  out  clog2(N)  index of the granted master; 0 when idle.
- o_busy  out  1  high whenever any grant bit is high.

## Operation
- State IDLE: no grant.
- State GRANT: exactly one o_grant bit high; the owner is held in `owner`.
- Winner selection (arbitration point):
  - Fixed mode: lowest requesting index.
  - RR mode: first requesting index scanning from (last+1) mod N upward with wrap.
  - `last` updates to the winner on every new grant.
- i_rr_mode is sampled only at arbitration points. A mode change mid-tenure has no effect until the next arbitration.
- IDLE:
  - i_request == 0: stay in IDLE.
  - Otherwise: go to GRANT with the selected winner and set hold_cnt = 0.
- GRANT, owner's request is low (release):
  - Arbitrate among the remaining requests with no dead cycle.
  - If none remain, go to IDLE.
- GRANT, owner's request is high and MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1 (timeout):
  - Arbitrate with the owner's bit masked out.
  - If no other request exists, re-grant the same owner with hold_cnt = 0.
- GRANT, otherwise: keep the owner and increment hold_cnt.
- Requests other than the owner's never pre-empt a tenure.
- hold_cnt width is clog2(MAX_HOLD+1). It never exceeds MAX_HOLD-1.
- Reset state:
  - IDLE, o_grant = 0, o_grant_id = 0, o_busy = 0, hold_cnt = 0.
  - last = N-1, so index 0 wins the first round-robin arbitration.

## Timing
- All outputs are Moore and registered; there is no combinational path from i_request to o_grant.
- Request first high in cycle t from IDLE: grant visible in cycle t+1.
- Release sampled at edge e (owner request low during the cycle before e):
  - The new grant, or IDLE, is visible after e.
  - The old grant deasserts at the same edge the new one asserts. The handoff is gapless and never overlaps.
- A tenure with continuous request lasts exactly MAX_HOLD cycles when another master is waiting.
- Resetn low at any edge, including mid-tenure: all outputs return to their reset values after that edge. The counter and `last` are reinitialised.
- Requests asserted while Resetn is low are ignored. The earliest grant is one cycle after the first edge with Resetn high.

## Structure
- Package arb_pkg:
  - State encoding constants IDLE = 1'b0, GRANT = 1'b1.
  - A clog2 helper function.
- Sub-module arb_pick:
  - Combinational rotating priority picker.
  - Inputs: request vector, mask, base index, mode.
  - Outputs: valid, winner index, one-hot winner.
  - Instantiated once; the FSM, hold counter and `last` pointer stay in rr_arbiter_n.

## Test plan
(N=4, MAX_HOLD=4 unless noted.)
- Reset and first grant: hold Resetn low 3 cycles with i_request=4'b1111 -> outputs stay 0 throughout. Release Resetn -> o_grant=4'b0001, o_grant_id=0 one cycle later.
- Fixed-priority handoff: i_rr_mode=0, i_request=4'b0110. Drop bit 1 after 2 cycles -> grant 4'b0010 for 2 cycles, then 4'b0100 in the very next cycle with no idle gap.
- Round-robin rotation: i_rr_mode=1, all four requesting continuously -> grant sequence 0,1,2,3,0, each lasting exactly 4 cycles. o_busy stays 1 throughout.
- Timeout with a sole requester: only bit 2 high for 12 cycles -> o_grant=4'b0100 held for all 12 cycles. hold_cnt wraps to 0 every 4 cycles.
- Unlimited hold: MAX_HOLD=0, i_request=4'b0011 -> master 0 keeps the grant for 50 cycles until it drops, then master 1 is granted the next cycle.
- Mid-tenure reset and mode switch: pull Resetn low during master 3's grant -> outputs are 0 next cycle and the next RR grant goes to master 0. Toggle i_rr_mode mid-tenure -> the current owner is unaffected.
